// File: rtl/muldiv_ctrl.sv
// HI/LO multiply-divide unit: fixed-latency mult/div with pipeline stall and mthi/mtlo.
// Results are computed at issue, held pending, and committed on the last busy cycle.
module muldiv_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        hi_we,
  input  logic        lo_we,
  input  logic        flush,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAXC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic          pend_we_q, pend_we_d;

  logic          accept, expire;
  logic          is_div, is_signed;
  logic [63:0]   mul_a, mul_b, prod;
  logic          a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, b_safe, q_mag, r_mag, quo, rem;

  assign is_div    = md_op[1];
  assign is_signed = ~md_op[0];
  assign accept    = (state_q == IDLE) & start & ~flush;
  assign expire    = (state_q == RUN) & (cnt_q == '0) & ~flush;

  // Signed divide works on magnitudes so the most-negative dividend cannot overflow.
  always_comb begin
    mul_a  = is_signed ? {{32{src_a[31]}}, src_a} : {32'd0, src_a};
    mul_b  = is_signed ? {{32{src_b[31]}}, src_b} : {32'd0, src_b};
    prod   = mul_a * mul_b;
    a_neg  = is_signed & src_a[31];
    b_neg  = is_signed & src_b[31];
    a_mag  = a_neg ? (32'd0 - src_a) : src_a;
    b_mag  = b_neg ? (32'd0 - src_b) : src_b;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quo    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    rem    = a_neg ? (32'd0 - r_mag) : r_mag;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (flush || cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state_q == RUN);
    done  = expire;
    stall = md_use_D & (busy | start);
  end

  always_comb begin
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_we_d = pend_we_q;
    if (accept) begin
      cnt_d = is_div ? CW'(DIV_CYC - 1) : CW'(MULT_CYC - 1);
      if (is_div) begin
        pend_we_d = (src_b != 32'd0);
        pend_hi_d = rem;
        pend_lo_d = quo;
      end else begin
        pend_we_d = 1'b1;
        pend_hi_d = prod[63:32];
        pend_lo_d = prod[31:0];
      end
    end else if (state_q == RUN) begin
      if (flush || cnt_q == '0) begin
        if (expire && pend_we_q) begin
          hi_d = pend_hi_q;
          lo_d = pend_lo_q;
        end
        cnt_d     = '0;
        pend_we_d = 1'b0;
        pend_hi_d = 32'd0;
        pend_lo_d = 32'd0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end else if (!start) begin
      // Any start (even one killed by flush) drops a coincident mthi/mtlo.
      if (hi_we) hi_d = src_a;
      if (lo_we) lo_d = src_a;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_we_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_we_q <= pend_we_d;
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed plus randomized checks of muldiv_ctrl against an arithmetic reference model.
module tb_muldiv_ctrl;

  localparam int MULT_CYC = 5;
  localparam int DIV_CYC  = 10;

  logic        clk = 1'b0;
  logic        rst_n, start, hi_we, lo_we, flush, md_use_D;
  logic [1:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, stall, done;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;
  logic [31:0] hi_m = 32'd0;
  logic [31:0] lo_m = 32'd0;

  always #5 clk = ~clk;

  muldiv_ctrl #(.MULT_CYC(MULT_CYC), .DIV_CYC(DIV_CYC)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .hi_we(hi_we), .lo_we(lo_we),
    .flush(flush), .md_use_D(md_use_D), .busy(busy), .stall(stall),
    .done(done), .hi(hi), .lo(lo)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit integer arithmetic straight from the op definitions.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output bit we, output logic [31:0] h, output logic [31:0] l);
    longint sa, sb, p, q, r;
    sa = op[0] ? longint'({32'd0, a}) : longint'($signed(a));
    sb = op[0] ? longint'({32'd0, b}) : longint'($signed(b));
    we = 1'b1;
    h  = 32'd0;
    l  = 32'd0;
    if (!op[1]) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      we = 1'b0;
    end else begin
      q = sa / sb;
      r = sa % sb;
      h = r[31:0];
      l = q[31:0];
    end
  endtask

  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_d, input int flush_at);
    int n;
    bit we, flushed;
    logic [31:0] eh, el;
    n = op[1] ? DIV_CYC : MULT_CYC;
    flushed = 1'b0;
    model(op, a, b, we, eh, el);
    @(posedge clk); #1;
    start = 1'b1; md_op = op; src_a = a; src_b = b; md_use_D = use_d;
    hi_we = 1'b1; lo_we = 1'b1;
    #1;
    chk("stall_issue", {31'd0, stall}, {31'd0, use_d});
    chk("busy_issue", {31'd0, busy}, 32'd0);
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      start = (k == 3);
      hi_we = (k == 2);
      lo_we = (k == 2);
      src_a = 32'hDEAD_BEEF;
      flush = (k == flush_at);
      #1;
      chk("busy_run", {31'd0, busy}, 32'd1);
      chk("done_run", {31'd0, done}, {31'd0, (k == n) && (k != flush_at)});
      chk("stall_run", {31'd0, stall}, {31'd0, use_d});
      chk("hi_run", hi, hi_m);
      chk("lo_run", lo, lo_m);
      if (k == flush_at) begin
        flushed = 1'b1;
        break;
      end
    end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    #1;
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_after", {31'd0, done}, 32'd0);
    chk("stall_after", {31'd0, stall}, 32'd0);
    if (!flushed && we) begin
      hi_m = eh;
      lo_m = el;
    end
    chk("hi_result", hi, hi_m);
    chk("lo_result", lo, lo_m);
    $display("op=%0d a=%h b=%h flush_at=%0d -> hi=%h lo=%h", op, a, b, flush_at, hi, lo);
    md_use_D = 1'b0;
  endtask

  task automatic mt(input bit wh, input bit wl, input logic [31:0] val);
    @(posedge clk); #1;
    hi_we = wh; lo_we = wl; src_a = val;
    @(posedge clk); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    if (wh) hi_m = val;
    if (wl) lo_m = val;
    #1;
    chk("mt_hi", hi, hi_m);
    chk("mt_lo", lo, lo_m);
    $display("mt hi_we=%0b lo_we=%0b val=%h -> hi=%h lo=%h", wh, wl, val, hi, lo);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          sel, fa;
    rst_n = 1'b0; start = 1'b1; md_op = 2'd0; src_a = 32'd0; src_b = 32'd0;
    hi_we = 1'b0; lo_we = 1'b0; flush = 1'b0; md_use_D = 1'b1;
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall_start", {31'd0, stall}, 32'd1);
    start = 1'b0;
    #1;
    chk("rst_stall_idle", {31'd0, stall}, 32'd0);
    md_use_D = 1'b0;
    #9 rst_n = 1'b1;

    do_op(2'd0, 32'hFFFF_FFFD, 32'd5, 1'b1, 0);
    chk("mult_hi_const", hi, 32'hFFFF_FFFF);
    chk("mult_lo_const", lo, 32'hFFFF_FFF1);
    do_op(2'd3, 32'd7, 32'd2, 1'b0, 0);
    chk("divu_lo_const", lo, 32'd3);
    chk("divu_hi_const", hi, 32'd1);
    do_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    chk("div_lo_const", lo, 32'hFFFF_FFFD);
    chk("div_hi_const", hi, 32'hFFFF_FFFF);

    mt(1'b1, 1'b0, 32'h11);
    mt(1'b0, 1'b1, 32'h22);
    do_op(2'd2, 32'd1234, 32'd0, 1'b0, 0);
    chk("div0_hi", hi, 32'h11);
    chk("div0_lo", lo, 32'h22);

    do_op(2'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0, 3);
    chk("flush_hi", hi, 32'h11);
    mt(1'b1, 1'b0, 32'hABCD);
    do_op(2'd3, 32'd100, 32'd3, 1'b1, DIV_CYC);

    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; md_op = 2'd0; src_a = 32'd3; src_b = 32'd4; hi_we = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0; hi_we = 1'b0;
    #1;
    chk("flush_start_busy", {31'd0, busy}, 32'd0);
    chk("flush_start_hi", hi, hi_m);
    $display("start+flush -> busy=%0b hi=%h", busy, hi);

    do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 9);
      rb  = (sel == 0) ? 32'd0 : (sel == 1) ? 32'hFFFF_FFFF :
            (sel == 2) ? 32'($urandom_range(1, 16)) : $urandom;
      if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
      fa  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : 0;
      do_op(rop, ra, rb, 1'($urandom_range(0, 1)), fa);
      if ($urandom_range(0, 4) == 0) mt(1'($urandom_range(0, 1)), 1'b1, $urandom);
    end

    mt(1'b1, 1'b1, 32'h5555_AAAA);
    @(posedge clk); #1;
    start = 1'b1; md_op = 2'd3; src_a = 32'd100; src_b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_done", {31'd0, done}, 32'd0);
    chk("async_rst_hi", hi, 32'd0);
    chk("async_rst_lo", lo, 32'd0);
    hi_m = 32'd0;
    lo_m = 32'd0;
    #2 rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      chk("post_rst_busy", {31'd0, busy}, 32'd0);
      chk("post_rst_hi", hi, hi_m);
      chk("post_rst_lo", lo, lo_m);
    end
    $display("reset mid-divide -> busy=%0b hi=%h lo=%h", busy, hi, lo);
    do_op(2'd0, 32'd6, 32'd7, 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
